seg_display_ctrl: RTL and testbench



---
 rtl/seg_display_ctrl_pkg.sv | 33 +++
 rtl/seg_display_ctrl_hex_decode.sv | 20 ++
 rtl/seg_display_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seg_display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Register map, CTRL field layout and hex-to-segment table shared
//            by the 7-segment display controller and its decoder.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam logic [1:0] C_ADDR_VALUE  = 2'd0;
    localparam logic [1:0] C_ADDR_CTRL   = 2'd1;
    localparam logic [1:0] C_ADDR_RAW    = 2'd2;
    localparam logic [1:0] C_ADDR_STATUS = 2'd3;

    localparam int C_CTRL_EN_LSB  = 0;
    localparam int C_CTRL_EN_W    = 4;
    localparam int C_CTRL_DP_LSB  = 4;
    localparam int C_CTRL_DP_W    = 4;
    localparam int C_CTRL_BRT_LSB = 8;
    localparam int C_CTRL_BRT_W   = 4;
    localparam int C_CTRL_RAW_BIT = 12;
    localparam int C_CTRL_W       = 13;

    localparam logic [C_CTRL_W-1:0] C_CTRL_RST = 13'h0F0F;

    // Active-low g..a in [6:0]; dp bit [7] is always off in the table
    localparam logic [7:0] C_HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage : display_pkg
`default_nettype wire

// File: rtl/seg_display_ctrl_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_hex_decode
// Purpose  : Combinational hex nibble to active-low 7-segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module seg_hex_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    logic [7:0] w_entry;

    assign w_entry = C_HEX_SEG[nibble];
    assign seg_n   = w_entry[6:0];

endmodule : seg_hex_decode
`default_nettype wire

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_ctrl
// Purpose  : Memory-mapped 4-digit multiplexed 7-segment display controller
//            with per-digit enable, decimal point, brightness PWM, raw mode.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [3:0]  anodes,
    output logic [7:0]  segments
);

    localparam int SUB   = SCAN_DIV / 16;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

    logic [15:0]         r_value_stg, r_value_act;
    logic [C_CTRL_W-1:0] r_ctrl_stg,  r_ctrl_act;
    logic [31:0]         r_raw_stg,   r_raw_act;

    logic [SUB_W-1:0]    r_sub_cnt;
    logic [3:0]          r_phase;
    logic [1:0]          r_digit;
    logic                r_frame_done;

    logic [31:0]         r_rd_data;
    logic [3:0]          r_anodes;
    logic [7:0]          r_segments;

    logic                w_sub_wrap;
    logic                w_phase_wrap;
    logic                w_frame_end;
    logic                w_status_wr;

    logic [3:0]          w_en_mask;
    logic [3:0]          w_dp_mask;
    logic [3:0]          w_brt;
    logic                w_raw_mode;
    logic [3:0]          w_nibble;
    logic [6:0]          w_hex_seg;
    logic [7:0]          w_raw_byte;
    logic [7:0]          w_pattern;
    logic                w_lit;

    assign w_sub_wrap   = (r_sub_cnt == SUB_W'(SUB - 1));
    assign w_phase_wrap = w_sub_wrap && (r_phase == 4'hF);
    assign w_frame_end  = w_phase_wrap && (r_digit == 2'd3);
    assign w_status_wr  = wr_en && (wr_addr == C_ADDR_STATUS);

    // Staging registers: CPU-visible, free to change at any time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_stg <= 16'h0000;
            r_ctrl_stg  <= C_CTRL_RST;
            r_raw_stg   <= 32'hFFFF_FFFF;
        end else if (wr_en) begin
            case (wr_addr)
                C_ADDR_VALUE: r_value_stg <= wr_data[15:0];
                C_ADDR_CTRL:  r_ctrl_stg  <= wr_data[C_CTRL_W-1:0];
                C_ADDR_RAW:   r_raw_stg   <= wr_data;
                default:      ;
            endcase
        end
    end

    // Non-blocking read of staging means a same-cycle write lands next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_act <= 16'h0000;
            r_ctrl_act  <= C_CTRL_RST;
            r_raw_act   <= 32'hFFFF_FFFF;
        end else if (w_frame_end) begin
            r_value_act <= r_value_stg;
            r_ctrl_act  <= r_ctrl_stg;
            r_raw_act   <= r_raw_stg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub_cnt <= '0;
            r_phase   <= 4'd0;
            r_digit   <= 2'd0;
        end else begin
            r_sub_cnt <= w_sub_wrap ? '0 : r_sub_cnt + SUB_W'(1);
            if (w_sub_wrap) begin
                r_phase <= r_phase + 4'd1;
            end
            if (w_phase_wrap) begin
                r_digit <= r_digit + 2'd1;
            end
        end
    end

    // Set has priority over a simultaneous CPU clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else if (w_frame_end) begin
            r_frame_done <= 1'b1;
        end else if (w_status_wr) begin
            r_frame_done <= 1'b0;
        end
    end

    assign w_en_mask  = r_ctrl_act[C_CTRL_EN_LSB  +: C_CTRL_EN_W];
    assign w_dp_mask  = r_ctrl_act[C_CTRL_DP_LSB  +: C_CTRL_DP_W];
    assign w_brt      = r_ctrl_act[C_CTRL_BRT_LSB +: C_CTRL_BRT_W];
    assign w_raw_mode = r_ctrl_act[C_CTRL_RAW_BIT];
    assign w_nibble   = r_value_act[{r_digit, 2'b00} +: 4];
    assign w_raw_byte = r_raw_act[{r_digit, 3'b000} +: 8];

    seg_hex_decode u_hex_decode (
        .nibble (w_nibble),
        .seg_n  (w_hex_seg)
    );

    assign w_pattern = w_raw_mode ? w_raw_byte : {~w_dp_mask[r_digit], w_hex_seg};
    assign w_lit     = w_en_mask[r_digit] && (r_phase <= w_brt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_anodes   <= 4'hF;
            r_segments <= 8'hFF;
        end else if (w_lit) begin
            r_anodes   <= ~(4'b0001 << r_digit);
            r_segments <= w_pattern;
        end else begin
            r_anodes   <= 4'hF;
            r_segments <= 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= 32'h0;
        end else if (rd_en) begin
            case (rd_addr)
                C_ADDR_VALUE: r_rd_data <= {16'h0, r_value_stg};
                C_ADDR_CTRL:  r_rd_data <= {{(32-C_CTRL_W){1'b0}}, r_ctrl_stg};
                C_ADDR_RAW:   r_rd_data <= r_raw_stg;
                default:      r_rd_data <= {29'h0, r_frame_done, r_digit};
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign anodes   = r_anodes;
    assign segments = r_segments;

endmodule : seg_display_ctrl
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_ctrl
// Purpose  : Directed self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  anodes;
    logic [7:0]  segments;

    always #5 clk = ~clk;

    seg_display_ctrl #(.SCAN_DIV(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .anodes   (anodes),
        .segments (segments)
    );

    typedef struct {
        int          t;
        logic [11:0] pins;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    // Reference state: t counts cycles since reset release (frame = 128)
    int          t;
    logic [15:0] m_val, a_val;
    logic [12:0] m_ctrl, a_ctrl;
    logic [31:0] m_raw, a_raw, m_rd;
    logic        m_fd;
    logic [6:0]  hex_tab [16];

    task automatic cyc(input logic r, input logic we, input logic [1:0] wa,
                       input logic [31:0] wd, input logic re, input logic [1:0] ra);
        exp_t       e;
        int         d;
        int         ph;
        logic       lit;
        logic [7:0] pat;
        logic [3:0] an;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        e.t = t;
        if (r) begin
            e.pins = 12'hFFF;
            m_val = 16'h0; a_val = 16'h0;
            m_ctrl = 13'h0F0F; a_ctrl = 13'h0F0F;
            m_raw = 32'hFFFF_FFFF; a_raw = 32'hFFFF_FFFF;
            m_fd = 1'b0; m_rd = 32'h0; t = 0;
        end else begin
            d   = (t / 32) % 4;
            ph  = (t / 2) % 16;
            lit = a_ctrl[d] && (ph <= int'(a_ctrl[11:8]));
            if (a_ctrl[12]) pat = a_raw[d*8 +: 8];
            else            pat = {~a_ctrl[4+d], hex_tab[a_val[d*4 +: 4]]};
            an = 4'hF;
            an[d] = 1'b0;
            e.pins = lit ? {an, pat} : 12'hFFF;
            if (re) begin
                case (ra)
                    2'd0:    m_rd = {16'h0, m_val};
                    2'd1:    m_rd = {19'h0, m_ctrl};
                    2'd2:    m_rd = m_raw;
                    default: m_rd = {29'h0, m_fd, 2'(d)};
                endcase
            end
            if (t % 128 == 127) begin
                a_val = m_val; a_ctrl = m_ctrl; a_raw = m_raw;
            end
            if (we) begin
                case (wa)
                    2'd0:    m_val  = wd[15:0];
                    2'd1:    m_ctrl = wd[12:0];
                    2'd2:    m_raw  = wd;
                    default: m_fd   = 1'b0;
                endcase
            end
            if (t % 128 == 127) m_fd = 1'b1;
            t++;
        end
        e.rd = m_rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        assert ({anodes, segments} === e.pins)
        else begin
            bad++;
            $error("FAIL pins t=%0d got=%h exp=%h", e.t, {anodes, segments}, e.pins);
        end
        total++;
        assert (rd_data === e.rd)
        else begin
            bad++;
            $error("FAIL rd_data t=%0d got=%h exp=%h", e.t, rd_data, e.rd);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        cyc(1'b0, 1'b1, a, v, 1'b0, 2'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, a);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 2000 && t < target; k++) idle();
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 32'h0;
        rd_en = 1'b0; rd_addr = 2'd0; t = 0;

        repeat (3) cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        rd(2'd3);

        run_to(40);
        wr(2'd0, 32'h0000_12A0);

        run_to(200);
        wr(2'd1, 32'h0000_0015);

        run_to(300);
        wr(2'd2, 32'h7F3F_06FF);
        wr(2'd1, 32'h0000_1F0F);

        run_to(450);
        wr(2'd3, 32'h0);
        rd(2'd3);

        // Clear on the boundary cycle itself: the set must survive
        run_to(511);
        wr(2'd3, 32'h0);
        rd(2'd3);
        wr(2'd3, 32'h0);
        rd(2'd3);
        rd(2'd0);
        rd(2'd1);
        rd(2'd2);
        wr(2'd0, 32'h0000_BEEF);

        run_to(586);
        cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        rd(2'd3);
        rd(2'd0);
        repeat (140) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seg_display_ctrl
`default_nettype wire
